// File: rtl/control_pkg.sv
// Shared definitions for the RV32I main control unit: opcodes, ALU op classes
// and the bundled control word carried from decode into execute.
package control_pkg;

    localparam int OPCODE_W = 7;
    localparam int ALU_OP_W = 3;

    typedef logic [OPCODE_W-1:0] opcode_t;
    typedef logic [ALU_OP_W-1:0] alu_op_t;

    localparam opcode_t OPCODE_R     = 7'b0110011;
    localparam opcode_t OPCODE_I     = 7'b0010011;
    localparam opcode_t OPCODE_L     = 7'b0000011;
    localparam opcode_t OPCODE_S     = 7'b0100011;
    localparam opcode_t OPCODE_B     = 7'b1100011;
    localparam opcode_t OPCODE_LUI   = 7'b0110111;
    localparam opcode_t OPCODE_AUIPC = 7'b0010111;
    localparam opcode_t OPCODE_JAL   = 7'b1101111;
    localparam opcode_t OPCODE_JALR  = 7'b1100111;

    localparam alu_op_t ALU_ADD = 3'b000;
    localparam alu_op_t ALU_BR  = 3'b001;
    localparam alu_op_t ALU_R   = 3'b010;
    localparam alu_op_t ALU_I   = 3'b011;
    localparam alu_op_t ALU_LUI = 3'b100;

    typedef struct packed {
        logic    reg_write;
        alu_op_t alu_op;
        logic    alu_src;
        logic    mem_write;
        logic    mem_read;
        logic    mem_to_reg;
        logic    branch;
        logic    jump;
        logic    illegal;
    } ctrl_t;

    // A bubble: nothing writes, nothing touches memory, nothing redirects.
    localparam ctrl_t CTRL_NOP = '0;

    localparam ctrl_t CTRL_ILLEGAL = '{
        reg_write:  1'b0,
        alu_op:     ALU_ADD,
        alu_src:    1'b0,
        mem_write:  1'b0,
        mem_read:   1'b0,
        mem_to_reg: 1'b0,
        branch:     1'b0,
        jump:       1'b0,
        illegal:    1'b1
    };

    function automatic ctrl_t make_ctrl(
        input logic    reg_write,
        input alu_op_t alu_op,
        input logic    alu_src,
        input logic    mem_write,
        input logic    mem_read,
        input logic    mem_to_reg,
        input logic    branch,
        input logic    jump
    );
        ctrl_t c;
        c.reg_write  = reg_write;
        c.alu_op     = alu_op;
        c.alu_src    = alu_src;
        c.mem_write  = mem_write;
        c.mem_read   = mem_read;
        c.mem_to_reg = mem_to_reg;
        c.branch     = branch;
        c.jump       = jump;
        c.illegal    = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/control_decode.sv
// Purely combinational opcode -> control word decode, including the illegal flag.
module control_decode
    import control_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode_i,
    output ctrl_t               ctrl_o
);

    always_comb begin
        // NOTE: the default assignment ahead of the case keeps this block latch-free
        // and makes any unlisted opcode (or X/Z in simulation) decode as illegal.
        ctrl_o = CTRL_ILLEGAL;
        case (opcode_i)
            //                              rw    alu_op   src   mw    mr    m2r   br    jmp
            OPCODE_R:     ctrl_o = make_ctrl(1'b1, ALU_R,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            OPCODE_I:     ctrl_o = make_ctrl(1'b1, ALU_I,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            OPCODE_L:     ctrl_o = make_ctrl(1'b1, ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            OPCODE_S:     ctrl_o = make_ctrl(1'b0, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            OPCODE_B:     ctrl_o = make_ctrl(1'b0, ALU_BR,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            OPCODE_LUI:   ctrl_o = make_ctrl(1'b1, ALU_LUI, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            OPCODE_AUIPC: ctrl_o = make_ctrl(1'b1, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            OPCODE_JAL:   ctrl_o = make_ctrl(1'b1, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            OPCODE_JALR:  ctrl_o = make_ctrl(1'b1, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            default:      ctrl_o = CTRL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control.sv
// RV32I main control unit: decodes the opcode and registers the control word
// toward execute, with flush (bubble) taking priority over enable (stall = hold).
module control
    import control_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                en_i,
    input  logic                flush_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    output logic                reg_write_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic                alu_src_o,
    output logic                mem_write_o,
    output logic                mem_read_o,
    output logic                men_to_reg_o,
    output logic                branch_o,
    output logic                jump_o,
    output logic                illegal_o
);

    ctrl_t dec_ctrl;
    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    control_decode u_decode (
        .opcode_i (opcode_i),
        .ctrl_o   (dec_ctrl)
    );

    always_comb begin
        ctrl_d = ctrl_q;
        if (flush_i) begin
            ctrl_d = CTRL_NOP;
        end else if (en_i) begin
            ctrl_d = dec_ctrl;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_n_i) begin
            ctrl_q <= CTRL_NOP;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign reg_write_o  = ctrl_q.reg_write;
    assign alu_op_o     = ctrl_q.alu_op;
    assign alu_src_o    = ctrl_q.alu_src;
    assign mem_write_o  = ctrl_q.mem_write;
    assign mem_read_o   = ctrl_q.mem_read;
    assign men_to_reg_o = ctrl_q.mem_to_reg;
    assign branch_o     = ctrl_q.branch;
    assign jump_o       = ctrl_q.jump;
    assign illegal_o    = ctrl_q.illegal;

endmodule

// File: tb/tb_control.sv
// Scoreboard bench for the control unit: a table-driven reference model queues
// expected control words, and a monitor compares them against the DUT each cycle.
module tb_control;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       en_i;
    logic       flush_i;
    logic [6:0] opcode_i;
    logic       reg_write_o;
    logic [2:0] alu_op_o;
    logic       alu_src_o;
    logic       mem_write_o;
    logic       mem_read_o;
    logic       men_to_reg_o;
    logic       branch_o;
    logic       jump_o;
    logic       illegal_o;

    control dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .en_i         (en_i),
        .flush_i      (flush_i),
        .opcode_i     (opcode_i),
        .reg_write_o  (reg_write_o),
        .alu_op_o     (alu_op_o),
        .alu_src_o    (alu_src_o),
        .mem_write_o  (mem_write_o),
        .mem_read_o   (mem_read_o),
        .men_to_reg_o (men_to_reg_o),
        .branch_o     (branch_o),
        .jump_o       (jump_o),
        .illegal_o    (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    // Control vector layout: {rw, alu_op[2:0], src, mw, mr, m2r, br, jmp, illegal}
    typedef struct {
        logic [10:0] v;
        logic [6:0]  op;
    } sb_entry_t;

    logic [10:0] ref_tbl [128];
    logic [6:0]  legal_ops [9];
    logic [10:0] exp_state;
    sb_entry_t   sb [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic logic [10:0] dut_vec();
        return {reg_write_o, alu_op_o, alu_src_o, mem_write_o, mem_read_o,
                men_to_reg_o, branch_o, jump_o, illegal_o};
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Reference table written straight from the decode rows; everything else is illegal.
    task automatic add_row(input logic [6:0] op, input logic [9:0] row);
        ref_tbl[op] = {row, 1'b0};
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ref_tbl[i] = 11'b000_0000_0001;
        add_row(7'b0110011, 10'b1_010_0_0_0_0_0_0);
        add_row(7'b0010011, 10'b1_011_1_0_0_0_0_0);
        add_row(7'b0000011, 10'b1_000_1_0_1_1_0_0);
        add_row(7'b0100011, 10'b0_000_1_1_0_0_0_0);
        add_row(7'b1100011, 10'b0_001_0_0_0_0_1_0);
        add_row(7'b0110111, 10'b1_100_1_0_0_0_0_0);
        add_row(7'b0010111, 10'b1_000_1_0_0_0_0_0);
        add_row(7'b1101111, 10'b1_000_1_0_0_0_0_1);
        add_row(7'b1100111, 10'b1_000_1_0_0_0_0_1);
        legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
    end

    // Drive one cycle of stimulus, then advance the model at the edge and queue its result.
    task automatic step(input logic en, input logic flush, input logic [6:0] op);
        sb_entry_t e;
        @(negedge clk_i);
        en_i     = en;
        flush_i  = flush;
        opcode_i = op;
        @(posedge clk_i);
        if (!rst_n_i)   exp_state = '0;
        else if (flush) exp_state = '0;
        else if (en)    exp_state = ref_tbl[op];
        e.v  = exp_state;
        e.op = op;
        sb.push_back(e);
    endtask

    // Monitor: outputs are stable at the falling edge, half a cycle after each update.
    initial begin
        sb_entry_t   e;
        logic [10:0] v;
        forever begin
            @(negedge clk_i);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                v = dut_vec();
                check($sformatf("ctrl op=%b", e.op), v, e.v);
                check("inv_mw_mr_exclusive", {10'd0, mem_write_o & mem_read_o}, 11'd0);
                check("inv_m2r_implies_mr", {10'd0, men_to_reg_o & ~mem_read_o}, 11'd0);
                check("inv_illegal_alone", {10'd0, illegal_o & (|v[10:1])}, 11'd0);
            end
        end
    end

    initial begin
        logic [6:0] op;
        rst_n_i   = 1'b0;
        en_i      = 1'b0;
        flush_i   = 1'b0;
        opcode_i  = '0;
        exp_state = '0;

        #1;
        check("reset_state", dut_vec(), 11'd0);
        step(1'b1, 1'b0, 7'b0110011);
        step(1'b1, 1'b0, 7'b0000011);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Sweep every legal opcode, one per cycle.
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, legal_ops[i]);

        // Asynchronous reset mid-run with nonzero outputs.
        @(negedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("async_reset_immediate", dut_vec(), 11'd0);
        exp_state = '0;
        step(1'b1, 1'b0, 7'b0000011);
        step(1'b1, 1'b0, 7'b1101111);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Illegal opcodes, then recovery.
        step(1'b1, 1'b0, 7'b1111111);
        step(1'b1, 1'b0, 7'b0110000);
        step(1'b1, 1'b0, 7'b0110011);

        // Stall: store then hold while opcode changes.
        step(1'b1, 1'b0, 7'b0100011);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 7'b0110011);

        // Flush beats enable, then decoding resumes.
        step(1'b1, 1'b0, 7'b0010011);
        step(1'b1, 1'b1, 7'b0110011);
        step(1'b1, 1'b0, 7'b0110011);
        step(1'b1, 1'b0, 7'b0000011);

        // Randomized run, biased half toward legal opcodes.
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 1) == 1) op = legal_ops[$urandom_range(0, 8)];
            else                           op = 7'($urandom);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, op);
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk_i);
        #1;
        check("scoreboard_drained", 11'(sb.size()), 11'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
